// File: rtl/write_fifo.sv
// FWFT FIFO after the writer arbiter; 1-cycle write-to-read, no empty bypass; writes while full need a same-cycle pop.
// Sticky overflow/underflow flags; o_almost_full is built only when WRITE_FIFO_AFULL_EN is defined.
module write_fifo #(
    parameter int DATA_WIDTH  = 8,
    parameter int DEPTH       = 4,
    parameter int AFULL_LEVEL = 3
) (
    input  logic                       i_clk,
    input  logic                       i_reset_n,
    input  logic                       i_we,
    input  logic [DATA_WIDTH-1:0]      i_wdata,
    input  logic                       i_re,
    output logic [DATA_WIDTH-1:0]      o_rdata,
    output logic                       o_empty,
    output logic                       o_full,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_overflow,
    output logic                       o_underflow
`ifdef WRITE_FIFO_AFULL_EN
    ,
    output logic                       o_almost_full
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    // Elaboration-time guard on the parameter set.
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || AFULL_LEVEL < 0 || AFULL_LEVEL > DEPTH) begin : g_bad_param
        $error("write_fifo: illegal DEPTH/AFULL_LEVEL");
    end

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic                  wr_ok;
    logic                  rd_ok;
    logic                  empty;
    logic                  full;

    assign empty = (count_q == '0);
    assign full  = (count_q == DEPTH_C);

    always_comb begin
        wr_ok       = i_we & (~full | i_re);
        rd_ok       = i_re & ~empty;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (wr_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (rd_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        // Full with a pop frees exactly one slot, so count stays at DEPTH.
        count_d = count_q + CNT_W'(wr_ok) - CNT_W'(rd_ok);
        if (i_we & full & ~i_re) begin
            overflow_d = 1'b1;
        end
        if (i_re & empty) begin
            underflow_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge i_clk) begin
        if (wr_ok) begin
            mem_q[wr_ptr_q] <= i_wdata;
        end
    end

`ifdef WRITE_FIFO_AFULL_EN
    logic afull_q, afull_d;

    always_comb begin
        afull_d = (count_d >= CNT_W'(AFULL_LEVEL));
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            afull_q <= 1'b0;
        end else begin
            afull_q <= afull_d;
        end
    end

    assign o_almost_full = afull_q;
`endif

    assign o_rdata     = mem_q[rd_ptr_q];
    assign o_empty     = empty;
    assign o_full      = full;
    assign o_count     = count_q;
    assign o_overflow  = overflow_q;
    assign o_underflow = underflow_q;

endmodule

// File: tb/tb_write_fifo.sv
// Directed bench for write_fifo (DATA_WIDTH=8, DEPTH=4); inputs change 1ns after posedge, outputs checked before the next edge.
module tb_write_fifo;

    logic       i_clk;
    logic       i_reset_n;
    logic       i_we;
    logic [7:0] i_wdata;
    logic       i_re;
    logic [7:0] o_rdata;
    logic       o_empty;
    logic       o_full;
    logic [2:0] o_count;
    logic       o_overflow;
    logic       o_underflow;
`ifdef WRITE_FIFO_AFULL_EN
    logic       o_almost_full;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    write_fifo #(.DATA_WIDTH(8), .DEPTH(4), .AFULL_LEVEL(3)) dut (
        .i_clk        (i_clk),
        .i_reset_n    (i_reset_n),
        .i_we         (i_we),
        .i_wdata      (i_wdata),
        .i_re         (i_re),
        .o_rdata      (o_rdata),
        .o_empty      (o_empty),
        .o_full       (o_full),
        .o_count      (o_count),
        .o_overflow   (o_overflow),
        .o_underflow  (o_underflow)
`ifdef WRITE_FIFO_AFULL_EN
        ,
        .o_almost_full(o_almost_full)
`endif
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply inputs for one clock, then settle 1ns past the edge.
    task automatic cycle(input logic we, input logic [7:0] wd, input logic re);
        i_we    = we;
        i_wdata = wd;
        i_re    = re;
        @(posedge i_clk);
        #1;
        i_we = 1'b0;
        i_re = 1'b0;
    endtask

    task automatic do_reset();
        i_reset_n = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        i_reset_n = 1'b1;
    endtask

    initial begin
        i_we      = 1'b0;
        i_re      = 1'b0;
        i_wdata   = 8'h00;
        i_reset_n = 1'b1;
        #2;
        do_reset();

        repeat (3) cycle(1'b0, 8'h00, 1'b0);
        check("rst_empty", 32'(o_empty), 32'd1);
        check("rst_full", 32'(o_full), 32'd0);
        check("rst_count", 32'(o_count), 32'd0);
        check("rst_ovf", 32'(o_overflow), 32'd0);
        check("rst_unf", 32'(o_underflow), 32'd0);
`ifdef WRITE_FIFO_AFULL_EN
        check("rst_afull", 32'(o_almost_full), 32'd0);
`endif

        // Fill with 0x11..0x44
        cycle(1'b1, 8'h11, 1'b0);
        check("fill1_count", 32'(o_count), 32'd1);
        check("fill1_rdata", 32'(o_rdata), 32'h11);
        check("fill1_empty", 32'(o_empty), 32'd0);
        cycle(1'b1, 8'h22, 1'b0);
        check("fill2_count", 32'(o_count), 32'd2);
`ifdef WRITE_FIFO_AFULL_EN
        check("fill2_afull", 32'(o_almost_full), 32'd0);
`endif
        cycle(1'b1, 8'h33, 1'b0);
        check("fill3_count", 32'(o_count), 32'd3);
        check("fill3_full", 32'(o_full), 32'd0);
`ifdef WRITE_FIFO_AFULL_EN
        check("fill3_afull", 32'(o_almost_full), 32'd1);
`endif
        cycle(1'b1, 8'h44, 1'b0);
        check("fill4_count", 32'(o_count), 32'd4);
        check("fill4_full", 32'(o_full), 32'd1);
        check("fill4_rdata", 32'(o_rdata), 32'h11);

        // Overflow: write while full, no pop
        cycle(1'b1, 8'h55, 1'b0);
        check("ovf_flag", 32'(o_overflow), 32'd1);
        check("ovf_count", 32'(o_count), 32'd4);
        check("ovf_rdata", 32'(o_rdata), 32'h11);

        check("pop1_rdata", 32'(o_rdata), 32'h11);
        cycle(1'b0, 8'h00, 1'b1);
        check("pop2_rdata", 32'(o_rdata), 32'h22);
        check("pop1_count", 32'(o_count), 32'd3);
        cycle(1'b0, 8'h00, 1'b1);
        check("pop3_rdata", 32'(o_rdata), 32'h33);
        cycle(1'b0, 8'h00, 1'b1);
        check("pop4_rdata", 32'(o_rdata), 32'h44);
        cycle(1'b0, 8'h00, 1'b1);
        check("drain_empty", 32'(o_empty), 32'd1);
        check("drain_count", 32'(o_count), 32'd0);
        check("drain_unf", 32'(o_underflow), 32'd0);
        check("ovf_sticky", 32'(o_overflow), 32'd1);

        // Clear sticky flags, then simultaneous write+pop while full
        do_reset();
        check("rst2_ovf", 32'(o_overflow), 32'd0);
        cycle(1'b1, 8'hA1, 1'b0);
        cycle(1'b1, 8'hA2, 1'b0);
        cycle(1'b1, 8'hA3, 1'b0);
        cycle(1'b1, 8'hA4, 1'b0);
        check("full2_full", 32'(o_full), 32'd1);
        cycle(1'b1, 8'h66, 1'b1);
        check("fwr_count", 32'(o_count), 32'd4);
        check("fwr_ovf", 32'(o_overflow), 32'd0);
        check("fwr_head", 32'(o_rdata), 32'hA2);
        cycle(1'b0, 8'h00, 1'b1);
        check("fdr_a3", 32'(o_rdata), 32'hA3);
        cycle(1'b0, 8'h00, 1'b1);
        check("fdr_a4", 32'(o_rdata), 32'hA4);
        cycle(1'b0, 8'h00, 1'b1);
        check("fdr_66", 32'(o_rdata), 32'h66);
        cycle(1'b0, 8'h00, 1'b1);
        check("fdr_empty", 32'(o_empty), 32'd1);

        // Empty with write+pop
        cycle(1'b1, 8'h77, 1'b1);
        check("ewr_unf", 32'(o_underflow), 32'd1);
        check("ewr_count", 32'(o_count), 32'd1);
        check("ewr_rdata", 32'(o_rdata), 32'h77);
        cycle(1'b0, 8'h00, 1'b1);
        check("ewr_drain", 32'(o_count), 32'd0);

        // Pointer wrap: streaming write+pop keeps one word in flight
        cycle(1'b1, 8'h81, 1'b0);
        for (int k = 2; k <= 6; k++) begin
            check($sformatf("wrap_head%0d", k - 1), 32'(o_rdata), 32'h80 + 32'(k - 1));
            cycle(1'b1, 8'h80 + 8'(k), 1'b1);
            check($sformatf("wrap_count%0d", k), 32'(o_count), 32'd1);
        end
        check("wrap_head6", 32'(o_rdata), 32'h86);
        cycle(1'b0, 8'h00, 1'b1);
        check("wrap_empty", 32'(o_empty), 32'd1);

        // Async reset mid-stream
        cycle(1'b1, 8'h91, 1'b0);
        cycle(1'b1, 8'h92, 1'b0);
        check("pre_arst_count", 32'(o_count), 32'd2);
        #2;
        i_reset_n = 1'b0;
        #1;
        check("arst_count", 32'(o_count), 32'd0);
        check("arst_empty", 32'(o_empty), 32'd1);
        check("arst_unf", 32'(o_underflow), 32'd0);
        @(posedge i_clk);
        #1;
        i_reset_n = 1'b1;
        cycle(1'b0, 8'h00, 1'b0);
        check("post_arst_count", 32'(o_count), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
